// File: rtl/led_matrix_scan_ctrl.sv
// led_matrix_scan_ctrl: time-multiplexed scan controller for a 5x7 LED dot matrix.
// Holds a 35-bit frame buffer (5 rows x 7 columns) and a single-pixel write port.
// Drives one row at a time for DWELL cycles and adds a blinking cursor overlay.
// Optional feature: define LED_SCAN_BLANK_EN to insert BLANK_CYC dark cycles
// between rows. Without it, rows are driven back to back.
module led_matrix_scan_ctrl #(
    parameter int DWELL     = 50000,
    parameter int BLANK_CYC = 500,
    parameter int BLINK_BIT = 24
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       en,
    input  logic       wr_en,
    input  logic [1:0] wr_op,
    input  logic [2:0] wr_row,
    input  logic [2:0] wr_col,
    input  logic       clr_all,
    input  logic       cursor_en,
    input  logic [2:0] cursor_row,
    input  logic [2:0] cursor_col,
    output logic [4:0] row,
    output logic [6:0] column,
    output logic       frame_start
);

    localparam int DWELL_W = $clog2(DWELL);
    localparam int BLINK_W = BLINK_BIT + 1;

`ifdef LED_SCAN_BLANK_EN
    typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;
    localparam int BLANK_W = $clog2(BLANK_CYC + 1);
    logic [BLANK_W-1:0] blank_q, blank_d;
`else
    typedef enum logic {IDLE, DRIVE} state_t;
`endif

    state_t             state_q, state_d;
    logic [2:0]         row_idx_q, row_idx_d, row_nxt;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [BLINK_W-1:0] blink_q;
    logic [4:0][6:0]    fb_q, fb_d;
    logic [6:0]         overlay;
    logic               drive_now;

    assign row_nxt   = (row_idx_q == 3'd4) ? 3'd0 : row_idx_q + 3'd1;
    assign drive_now = (state_q == DRIVE) && en;

    // Scan state register: FSM state, current row index and dwell/blank counters.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            state_q   <= IDLE;
            row_idx_q <= 3'd0;
            dwell_q   <= '0;
`ifdef LED_SCAN_BLANK_EN
            blank_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            dwell_q   <= dwell_d;
`ifdef LED_SCAN_BLANK_EN
            blank_q   <= blank_d;
`endif
        end
    end

    // Next-state logic: dwell on each row, optionally blank, then advance the row.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        row_idx_d = row_idx_q;
        dwell_d   = dwell_q;
`ifdef LED_SCAN_BLANK_EN
        blank_d   = blank_q;
`endif
        case (state_q)
            IDLE: begin
                state_d   = DRIVE;
                row_idx_d = 3'd0;
                dwell_d   = '0;
            end
            DRIVE: begin
                if (dwell_q == DWELL_W'(DWELL - 1)) begin
                    dwell_d = '0;
`ifdef LED_SCAN_BLANK_EN
                    state_d = BLANK;
                    blank_d = '0;
`else
                    row_idx_d = row_nxt;
`endif
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
`ifdef LED_SCAN_BLANK_EN
            BLANK: begin
                if (blank_q == BLANK_W'(BLANK_CYC - 1)) begin
                    state_d   = DRIVE;
                    row_idx_d = row_nxt;
                    blank_d   = '0;
                end else begin
                    blank_d = blank_q + BLANK_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        // Disabling the scan returns to IDLE with everything cleared; the buffer is kept.
        if (!en) begin
            state_d   = IDLE;
            row_idx_d = 3'd0;
            dwell_d   = '0;
`ifdef LED_SCAN_BLANK_EN
            blank_d   = '0;
`endif
        end
    end

    // Frame buffer update: clear-all wins, otherwise apply an in-range pixel op.
    always_comb begin
        fb_d = fb_q;
        if (clr_all) begin
            fb_d = '0;
        end else if (wr_en && (wr_row <= 3'd4) && (wr_col <= 3'd6)) begin
            case (wr_op)
                2'b00:   fb_d[wr_row][wr_col] = 1'b0;
                2'b01:   fb_d[wr_row][wr_col] = 1'b1;
                2'b10:   fb_d[wr_row][wr_col] = ~fb_q[wr_row][wr_col];
                default: fb_d[wr_row][wr_col] = fb_q[wr_row][wr_col];
            endcase
        end
    end

    // Frame buffer and free-running blink counter registers.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: the buffer is small flops, not RAM, so it can be reset to all-dark.
        if (rst) begin
            fb_q    <= '0;
            blink_q <= '0;
        end else begin
            fb_q    <= fb_d;
            blink_q <= blink_q + BLINK_W'(1);
        end
    end

    // Cursor overlay: one-hot cursor column on the cursor's row during the blink-on phase.
    always_comb begin
        overlay = 7'd0;
        if (cursor_en && blink_q[BLINK_BIT] && (cursor_row == row_idx_q) && (cursor_col <= 3'd6))
            overlay = 7'd1 << cursor_col;
    end

    // Registered pin drive; the column uses the post-write buffer so a write shows next cycle.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            row         <= 5'd0;
            column      <= 7'd0;
            frame_start <= 1'b0;
        end else begin
            row         <= drive_now ? (5'd1 << row_idx_q) : 5'd0;
            column      <= drive_now ? (fb_d[row_idx_q] | overlay) : 7'd0;
            frame_start <= drive_now && (row_idx_q == 3'd0) && (dwell_q == '0);
        end
    end

endmodule

// File: doc/led_matrix_scan_ctrl.md
Name: led_matrix_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 5x7 LED dot matrix.
- Owns a 35-bit frame buffer. Drives exactly one row at a time with that row's column pattern, so arbitrary patterns display without crosspoint ghosting.
- Provides a single-pixel write port for the canvas/editor logic and a blinking cursor overlay.
- Sits between the canvas/edit control and the matrix pins.

Parameters:
- DWELL, 50000: clock cycles each row is driven (1 ms at 50 MHz). Must be ≥ 2.
- BLANK_CYC, 500: all-off cycles inserted between rows. Used only with the optional feature; must be ≥ 1.
- BLINK_BIT, 24: bit of the free-running blink counter that gates the cursor. Counter width is BLINK_BIT+1.

Ports:
- CLOCK_50, input, 1: system clock, 50 MHz.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: scan enable. When low, outputs are dark and the frame buffer is retained.
- wr_en, input, 1: pixel write strobe, sampled each clock.
- wr_op, input, 2: write operation. 00 = clear, 01 = set, 10 = toggle, 11 = no-op.
- wr_row, input, 3: target row, 0..4.
- wr_col, input, 3: target column, 0..6.
- clr_all, input, 1: clear the entire frame buffer.
- cursor_en, input, 1: enable the cursor overlay.
- cursor_row, input, 3: cursor row, 0..4.
- cursor_col, input, 3: cursor column, 0..6.
- row, output, 5: one-hot active-high row drive. Bit r = row r.
- column, output, 7: active-high column data for the driven row.
- frame_start, output, 1: one-cycle pulse when row 0 begins driving.

Behaviour:
- Reset (rst=1 at a clock edge): frame buffer all 0; FSM to IDLE; row index 0; dwell and blink counters 0; row=0, column=0, frame_start=0. Reset overrides every other input, including mid-frame.
- FSM states: IDLE, DRIVE, BLANK. BLANK exists only with the optional feature.
- IDLE: outputs 0. If en=1, next state is DRIVE with row index 0 and dwell counter 0.
- DRIVE: dwell counter increments each cycle. On count DWELL-1, counter resets to 0 and the FSM moves to BLANK, or directly to the next row's DRIVE without the feature.
- Row index advances 0→1→2→3→4→0, wrapping after 4.
- BLANK: outputs 0 for BLANK_CYC cycles, then DRIVE of the next row.
- en=0 in any state: next state IDLE, row index 0, counters cleared. The frame buffer is untouched.
- Outputs are registered and lag the FSM by one cycle:
  - row = one-hot(row index) while in DRIVE, else 0.
  - column = fb[row index] | overlay while in DRIVE, else 0.
  - overlay = one-hot(cursor_col) when cursor_en=1, blink counter bit BLINK_BIT = 1, and cursor_row = current row index; else 0.
- frame_start asserts coincident with the first cycle that row = 00001 in each frame.
- The blink counter is free-running and does not depend on en.
- Write port:
  - The write commits at the edge where wr_en=1. It is visible on column in the following cycle if that row is being driven.
  - wr_row>4 or wr_col>6: write is ignored, with no side effects.
  - clr_all=1 has priority over a simultaneous wr_en. Buffer is all 0 after that edge.
  - Writes are accepted in every state, including IDLE and while en=0.
- Cursor coordinates out of range: no overlay.
- Each row is driven for exactly DWELL consecutive cycles. No row is ever driven simultaneously with another; row is always one-hot or zero.

Optional Feature:
- Macro LED_SCAN_BLANK_EN.
- Defined: BLANK state is inserted after every DRIVE. Frame period = 5*(DWELL+BLANK_CYC) cycles, and row/column are 0 during blanking to suppress ghosting.
- Undefined: no BLANK state. Rows are back-to-back, frame period = 5*DWELL cycles, and BLANK_CYC is unused.

Test Plan:
All scenarios use DWELL=4 and BLANK_CYC=1.
- Reset then en=1, feature off, empty buffer -> row sequence 00001,00010,00100,01000,10000, each held 4 cycles, column=0; frame_start pulses every 20 cycles.
- wr_en, op=01, row=2, col=3 -> column=0001000 only while row=00100. Then toggle (op=10) same pixel -> column=0 on the next visit.
- Feature on -> a 1-cycle row=0, column=0 gap between every pair of rows; frame period 25 cycles.
- wr_row=5 or wr_col=7 with op=01 -> buffer unchanged; all columns remain 0 over a full frame.
- clr_all=1 and wr_en(op=01, row0, col0) in the same cycle -> buffer all 0; column stays 0 on row 0.
- en dropped mid row 3 -> outputs 0 from the next cycle. en re-raised -> scan restarts at row 0 with frame_start, and buffer contents are preserved. rst mid-frame -> all outputs 0 and buffer cleared.
